c_result_drain: RTL and testbench

// - Downstream of the TPU core. After a matmul, it reads C-buffer words (each word is 4 x 32-bit accumulators).
// - Requantises each accumulator to int8 (arithmetic shift, optional rounding, saturation).
// - Packs the 4 results into one 32-bit word and streams it out on a valid/ready interface.
// - Leaves the C buffer untouched.

---
 rtl/c_result_drain_pkg.sv | 15 +
 rtl/c_result_drain_requant_lane.sv | 31 +++
 rtl/c_result_drain.sv | 188 ++++++++++++++++++
 tb/tb_c_result_drain.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c_result_drain_pkg.sv
// Shared types and constants for the C-buffer result drain.
package c_result_drain_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } state_e;

  localparam int unsigned LaneW = 32;
  localparam int unsigned Lanes = 4;
  localparam int          SatMax = 127;
  localparam int          SatMin = -128;

endpackage

// File: rtl/c_result_drain_requant_lane.sv
// One accumulator lane: optional round-half-up, arithmetic right shift, saturate to int8.
module c_result_drain_requant_lane
  import c_result_drain_pkg::*;
#(
  parameter bit ROUND = 1'b1
) (
  input  logic [LaneW-1:0] acc,
  input  logic [4:0]       shift,
  output logic [7:0]       q
);

  // Two guard bits keep acc + 2^30 from overflowing.
  logic signed [LaneW+1:0] v;
  logic signed [LaneW+1:0] y;

  always_comb begin
    v = {{2{acc[LaneW-1]}}, acc};
    if (ROUND && (shift != 5'd0)) begin
      v = v + (34'sd1 <<< (shift - 5'd1));
    end
    y = v >>> shift;
    if (y > 34'(SatMax)) begin
      q = 8'(SatMax);
    end else if (y < 34'(SatMin)) begin
      q = 8'(SatMin);
    end else begin
      q = y[7:0];
    end
  end

endmodule

// File: rtl/c_result_drain.sv
// Reads M x Ng C-buffer words in index order, requantises 4 lanes to int8 and streams them out
// through a small prefetch FIFO that hides the 1-cycle C read latency.
module c_result_drain
  import c_result_drain_pkg::*;
#(
  parameter bit          ROUND      = 1'b1,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   M,
  input  logic [7:0]   N,
  input  logic [4:0]   shift,
  output logic         busy,
  output logic         done,
  output logic         C_wr_en,
  output logic [15:0]  C_index,
  input  logic [127:0] C_data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic [3:0]   out_keep,
  output logic         out_last
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  state_e        state_q, state_d;
  logic [7:0]    m_q, n_q;
  logic [4:0]    shift_q;
  logic [7:0]    r_q;
  logic [5:0]    g_q;
  logic [15:0]   idx_q;
  logic          inflight_q;
  logic [3:0]    pend_keep_q;
  logic          pend_last_q;
  logic          done_q, done_d;

  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [3:0]    fifo_keep_q [FIFO_DEPTH];
  logic          fifo_last_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;

  logic          accept, issue, push, pop, last_now;
  logic [3:0]    keep_now;
  logic [8:0]    ng;
  logic [7:0]    lane_res [Lanes];
  logic [31:0]   push_data;

  assign ng        = ({1'b0, n_q} + 9'd3) >> 2;
  assign last_now  = (r_q == m_q - 8'd1) && ({3'b000, g_q} == ng - 9'd1);
  assign push      = inflight_q;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign accept    = (state_q == StIdle) && start && (M != 8'd0) && (N != 8'd0);
  // A same-cycle pop frees a slot, which keeps 1 beat/cycle with out_ready held high.
  assign issue     = (state_q == StRead) &&
                     ((32'(cnt_q) + 32'(inflight_q)) < (FIFO_DEPTH + 32'(pop)));

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign C_wr_en   = 1'b0;
  assign C_index   = idx_q;
  assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_keep  = out_valid ? fifo_keep_q[rd_ptr_q] : '0;
  assign out_last  = out_valid && fifo_last_q[rd_ptr_q];

  for (genvar gi = 0; gi < Lanes; gi++) begin : g_lane
    c_result_drain_requant_lane #(
      .ROUND(ROUND)
    ) u_lane (
      .acc  (C_data_out[LaneW*gi +: LaneW]),
      .shift(shift_q),
      .q    (lane_res[gi])
    );
  end

  always_comb begin
    keep_now  = '0;
    push_data = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      keep_now[i] = ({g_q, 2'(i)} < n_q);
      if (pend_keep_q[i]) begin
        push_data[8*i +: 8] = lane_res[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if ((M != 8'd0) && (N != 8'd0)) begin
            state_d = StRead;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (issue && last_now) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && out_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      done_q      <= 1'b0;
      m_q         <= '0;
      n_q         <= '0;
      shift_q     <= '0;
      r_q         <= '0;
      g_q         <= '0;
      idx_q       <= '0;
      inflight_q  <= 1'b0;
      pend_keep_q <= '0;
      pend_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      inflight_q <= issue;
      if (accept) begin
        m_q     <= M;
        n_q     <= N;
        shift_q <= shift;
        r_q     <= '0;
        g_q     <= '0;
        idx_q   <= '0;
      end else if (issue) begin
        pend_keep_q <= keep_now;
        pend_last_q <= last_now;
        if (!last_now) begin
          idx_q <= idx_q + 16'd1;
          if (r_q == m_q - 8'd1) begin
            r_q <= '0;
            g_q <= g_q + 6'd1;
          end else begin
            r_q <= r_q + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_keep_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= push_data;
        fifo_keep_q[wr_ptr_q] <= pend_keep_q;
        fifo_last_q[wr_ptr_q] <= pend_last_q;
        wr_ptr_q <= (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (!push && pop) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_c_result_drain.sv
// Scoreboard bench for c_result_drain: job driver queues expected beats, a monitor pops them.
module tb_c_result_drain;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   M = '0;
  logic [7:0]   N = '0;
  logic [4:0]   shift = '0;
  logic         busy, done, C_wr_en;
  logic [15:0]  C_index;
  logic [127:0] C_data_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic [3:0]   out_keep;
  logic         out_last;

  always #5 clk = ~clk;

  c_result_drain #(
    .ROUND     (1'b1),
    .FIFO_DEPTH(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .M         (M),
    .N         (N),
    .shift     (shift),
    .busy      (busy),
    .done      (done),
    .C_wr_en   (C_wr_en),
    .C_index   (C_index),
    .C_data_out(C_data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last)
  );

  // C buffer model: data appears one cycle after the address.
  logic [127:0] cmem [256];
  always @(posedge clk) C_data_out <= cmem[C_index[7:0]];

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    rmode = 0;
  beat_t expq[$];
  int    beats_seen = 0;
  int    done_seen = 0;
  int    first_valid_cyc = -1;
  int    first_hs_cyc = 0;
  int    last_hs_cyc = 0;
  int    done_cyc = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference requant: plain integer arithmetic on a wide signed value.
  function automatic logic [7:0] rq(input logic [31:0] acc, input int s);
    longint v;
    v = longint'($signed(acc));
    if (s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
    return v[7:0];
  endfunction

  task automatic push_model(input int m, input int n, input int s);
    beat_t b;
    int ng;
    logic [127:0] w;
    ng = (n + 3) / 4;
    for (int idx = 0; idx < m * ng; idx++) begin
      int g;
      g = idx / m;
      w = cmem[idx];
      b = '0;
      for (int i = 0; i < 4; i++) begin
        if (4 * g + i < n) begin
          b.k[i] = 1'b1;
          b.d[8*i +: 8] = rq(w[32*i +: 32], s);
        end
      end
      b.l = (idx == m * ng - 1);
      expq.push_back(b);
    end
  endtask

  task automatic fill_rand(input int words);
    logic [31:0] a;
    for (int idx = 0; idx < words; idx++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0: a = $urandom;
          1: a = 32'($urandom_range(0, 511)) - 32'd256;
          2: a = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
          default: a = 32'($signed($urandom) >>> $urandom_range(8, 30));
        endcase
        cmem[idx][32*i +: 32] = a;
      end
    end
  endtask

  initial begin : ready_drv
    int pat;
    pat = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          out_ready = (pat == 0) || (pat == 3);
          pat = (pat + 1) % 4;
        end
        4: out_ready = ((cyc % 12) < 3);
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    beat_t       e;
    logic        stall_prev;
    logic [36:0] held;
    int          stall_run;
    logic [15:0] idx_prev;
    stall_prev = 1'b0;
    stall_run  = 0;
    held       = '0;
    idx_prev   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
        stall_run  = 0;
      end else begin
        if (stall_prev) begin
          check("stall_stable", {out_valid, out_data, out_keep, out_last}, {1'b1, held});
        end
        if ((stall_run >= 2) && out_valid && !out_ready) begin
          check("index_held_full", C_index, idx_prev);
        end
        if (out_valid && !out_ready) stall_run++;
        else stall_run = 0;
        stall_prev = out_valid && !out_ready;
        held       = {out_data, out_keep, out_last};
        idx_prev   = C_index;
        if (out_valid && (first_valid_cyc < 0)) first_valid_cyc = cyc;
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            check("extra_beat", {out_data, out_keep, out_last}, 64'hDEAD);
          end else begin
            e = expq.pop_front();
            check("beat", {out_data, out_keep, out_last}, e);
          end
          if (beats_seen == 0) first_hs_cyc = cyc;
          beats_seen++;
          last_hs_cyc = cyc;
        end
        if (done) begin
          check("done_all_beats", expq.size(), 0);
          done_seen++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic run_job(input int m, input int n, input int s, input int rm, input bit mid,
                         input bit model);
    int d0, nbeats, t, start_c;
    rmode  = rm;
    nbeats = (m == 0 || n == 0) ? 0 : m * ((n + 3) / 4);
    if (model) push_model(m, n, s);
    @(posedge clk);
    #1;
    d0 = done_seen;
    beats_seen = 0;
    first_valid_cyc = -1;
    M = 8'(m);
    N = 8'(n);
    shift = 5'(s);
    start = 1'b1;
    start_c = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    M = 8'($urandom);
    N = 8'($urandom);
    shift = 5'($urandom);
    @(negedge clk);
    #1;
    if (nbeats == 0) begin
      check("zero_done_next", done_seen - d0, 1);
      check("zero_busy_low", busy, 0);
    end else begin
      check("busy_after_start", busy, 1);
    end
    for (t = 0; t < 3000 && done_seen == d0; t++) begin
      if (mid && t == 2) begin
        start = 1'b1;
        M = 8'd1;
        N = 8'd1;
      end
      if (mid && t == 3) start = 1'b0;
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    if (done_seen == d0) begin
      check("done_timeout", 0, 1);
      expq.delete();
    end else if (nbeats > 0) begin
      check("beat_count", beats_seen, nbeats);
      check("first_latency_ge2", 64'((first_valid_cyc - start_c) >= 2), 1);
      check("done_after_last", done_cyc - last_hs_cyc, 1);
      check("busy_low_at_done", busy, 0);
      if (rm == 0) check("throughput", last_hs_cyc - first_hs_cyc, nbeats - 1);
    end
    @(negedge clk);
    #1;
    check("done_one_cycle", done, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int d0;
    beat_t b;
    for (int i = 0; i < 256; i++) cmem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, out_valid, out_data, out_keep, out_last, C_index}, 0);
    check("wr_en_tied", C_wr_en, 0);
    rst_n = 1'b1;

    // Saturation at shift 0.
    for (int r = 0; r < 4; r++) begin
      cmem[r] = {32'd128, 32'd127, 32'hFFFF_FFFF, 32'(r)};
      b.d = {8'h7F, 8'h7F, 8'hFF, 8'(r)};
      b.k = 4'hF;
      b.l = (r == 3);
      expq.push_back(b);
    end
    run_job(4, 4, 0, 0, 0, 0);

    // Rounding corners at shift 4.
    cmem[0] = {32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFE8, 32'd24};
    b.d = 32'h807F_FF02;
    b.k = 4'hF;
    b.l = 1'b1;
    expq.push_back(b);
    run_job(1, 4, 4, 0, 0, 0);

    // Partial last column group.
    fill_rand(6);
    run_job(3, 6, 2, 0, 0, 1);

    // Backpressure patterns.
    fill_rand(8);
    run_job(8, 4, 5, 2, 0, 1);
    fill_rand(8);
    run_job(8, 4, 9, 4, 0, 1);

    // Degenerate sizes and a start while busy.
    run_job(4, 0, 0, 0, 0, 1);
    run_job(0, 5, 0, 0, 0, 1);
    fill_rand(12);
    run_job(4, 9, 3, 1, 1, 1);

    // Extreme dimensions.
    fill_rand(255);
    run_job(255, 1, 7, 0, 0, 1);
    fill_rand(64);
    run_job(1, 255, 31, 1, 0, 1);

    for (int j = 0; j < 8; j++) begin
      int m, n, s, rm;
      m  = $urandom_range(1, 10);
      n  = $urandom_range(1, 24);
      s  = $urandom_range(0, 3) != 0 ? $urandom_range(0, 12) : $urandom_range(13, 31);
      rm = $urandom_range(0, 3);
      if (rm == 3) rm = 4;
      fill_rand(m * ((n + 3) / 4));
      run_job(m, n, s, rm, 0, 1);
    end

    // Reset while draining the final beat.
    rmode = 3;
    cmem[0] = {32'd1, 32'd2, 32'd3, 32'd4};
    @(posedge clk);
    #1;
    M = 8'd1;
    N = 8'd4;
    shift = 5'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
    check("rst_pre_valid", out_valid, 1);
    repeat (3) @(negedge clk);
    #2;
    d0 = done_seen;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {busy, done, out_valid, out_data, out_keep, out_last, C_index}, 0);
    expq.delete();
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_done_after", done_seen - d0, 0);
    fill_rand(14);
    run_job(7, 7, 3, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
